normal_df_ctrl: RTL and testbench

// Control FSM that sequences the triangle-normal datapath: edge V2-V1, edge V3-V1, then their cross product.
// For each phase it selects the datapath mux/demux path, pulses the square-root start and waits for sqrt ready.
// It allows divider settling, then pulses the register load strobe.

---
 rtl/normal_df_ctrl_if.sv | 24 ++
 rtl/normal_df_ctrl.sv | 117 +++++++++++
 tb/tb_normal_df_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/normal_df_ctrl_if.sv
// Handshake bundle between the triangle-normal controller, its dispatcher and the normal datapath.
interface normal_df_ctrl_if;
    logic       start;
    logic       abort;
    logic       ready_sqrt;
    logic       sel1;
    logic       sel2;
    logic       start_sqrt;
    logic       sqrt_ready;
    logic [1:0] phase;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, abort, ready_sqrt,
        input  sel1, sel2, start_sqrt, sqrt_ready, phase, busy, done, error
    );

    modport slave (
        input  start, abort, ready_sqrt,
        output sel1, sel2, start_sqrt, sqrt_ready, phase, busy, done, error
    );
endinterface

// File: rtl/normal_df_ctrl.sv
// Sequences the triangle-normal datapath: edge V2-V1, edge V3-V1, then their cross product,
// each phase being sqrt start, ready wait, divider settle and register load.
module normal_df_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    normal_df_ctrl_if.slave  bus
);
    localparam int unsigned WaitW   = $clog2(TIMEOUT);
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WaitW-1:0]   WaitLast   = WaitW'(TIMEOUT - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StArm, StWait, StSettle, StLoad, StDone, StErr
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           p_q, p_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [SettleW-1:0]   settle_q, settle_d;
    logic                 sel1_q, sel1_d;
    logic                 sel2_q, sel2_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            p_q      <= '0;
            wait_q   <= '0;
            settle_q <= '0;
            sel1_q   <= 1'b0;
            sel2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            wait_q   <= wait_d;
            settle_q <= settle_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        wait_d   = wait_q;
        settle_d = settle_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (bus.start) begin
                    state_d = StStart;
                    p_d     = 2'd0;
                    sel1_d  = 1'b0;
                    sel2_d  = 1'b0;
                end
            end
            StStart: state_d = StArm;
            // A ready left over from the previous phase is deliberately skipped here.
            StArm: begin
                state_d = StWait;
                wait_d  = '0;
            end
            StWait: begin
                if (bus.ready_sqrt) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d = StLoad;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StLoad: begin
                if (p_q == 2'd2) begin
                    state_d = StDone;
                end else begin
                    state_d = StStart;
                    p_d     = p_q + 2'd1;
                    sel1_d  = 1'b1;
                    sel2_d  = (p_q == 2'd1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over everything but reset; mux selects hold their last value.
        if (bus.abort) begin
            state_d = StIdle;
            p_d     = p_q;
            sel1_d  = sel1_q;
            sel2_d  = sel2_q;
        end
    end

    logic busy;
    assign busy = state_q inside {StStart, StArm, StWait, StSettle, StLoad};

    assign bus.sel1       = sel1_q;
    assign bus.sel2       = sel2_q;
    assign bus.start_sqrt = (state_q == StStart);
    assign bus.sqrt_ready = (state_q == StLoad) && !bus.abort && !rst_i;
    assign bus.done       = (state_q == StDone) && !bus.abort && !rst_i;
    assign bus.busy       = busy;
    assign bus.phase      = busy ? p_q : 2'd3;
    assign bus.error      = (state_q == StErr);
endmodule

// File: tb/tb_normal_df_ctrl.sv
// Randomised and scripted bench for normal_df_ctrl against a phase/offset-based behavioural model.
module tb_normal_df_ctrl;
    localparam int S = 2;
    localparam int T = 64;

    logic clk;
    logic rst;
    normal_df_ctrl_if bus ();

    normal_df_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = -1000;

    // Model: a phase is k cycles old; k=0 start pulse, k=1 ignored, ready seen at k=r>=2,
    // load at k=r+1+S; no ready by k=T+1 means timeout.
    bit m_valid = 0;
    bit m_run = 0, m_done = 0, m_err = 0, m_sel1 = 0, m_sel2 = 0;
    int m_p = 0, m_k = 0, m_rdy = -1;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_err = 0; m_sel1 = 0; m_sel2 = 0;
            m_p = 0; m_k = 0; m_rdy = -1; m_valid = 1;
        end else if (bus.abort) begin
            m_run = 0; m_done = 0; m_err = 0;
        end else if (m_run) begin
            if (m_k >= 2 && m_rdy < 0 && bus.ready_sqrt) m_rdy = m_k;
            if (m_rdy >= 0 && m_k == m_rdy + 1 + S) begin
                if (m_p == 2) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_p++; m_k = 0; m_rdy = -1; m_sel1 = 1; m_sel2 = (m_p == 2);
                end
            end else if (m_rdy < 0 && m_k == T + 1) begin
                m_run = 0; m_err = 1;
            end else begin
                m_k++;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (bus.start) begin
            m_run = 1; m_err = 0; m_p = 0; m_k = 0; m_rdy = -1; m_sel1 = 0; m_sel2 = 0;
        end
    end

    // Packing: {phase[1:0], sel1, sel2, start_sqrt, sqrt_ready, busy, done, error}
    function automatic logic [8:0] model_out();
        logic ld, dn;
        int   ph;
        ld = m_run && m_rdy >= 0 && m_k == m_rdy + 1 + S && !bus.abort && !rst;
        dn = m_done && !bus.abort && !rst;
        ph = m_run ? m_p : 3;
        return {ph[1:0], m_sel1, m_sel2, m_run && m_k == 0, ld, m_run, dn, m_err};
    endfunction

    function automatic logic [8:0] dut_out();
        return {bus.phase, bus.sel1, bus.sel2, bus.start_sqrt, bus.sqrt_ready,
                bus.busy, bus.done, bus.error};
    endfunction

    logic [8:0] snap [128];
    int q_ss[$];
    int q_ld[$];
    int q_dn[$];

    always @(negedge clk) begin
        logic [8:0] d;
        logic [8:0] e;
        d = dut_out();
        e = model_out();
        if (m_valid) begin
            n_cmp++;
            if (d !== e) begin
                n_bad++;
                $display("FAIL model_cycle cyc=%0d t=%0t got=%b want=%b (ph,s1,s2,ss,ld,busy,dn,err)",
                         cyc, $time, d, e);
            end
        end
        if (cyc >= 0) begin
            if (cyc < 128) snap[cyc] = d;
            if (d[4]) q_ss.push_back(cyc);
            if (d[3]) q_ld.push_back(cyc);
            if (d[1]) q_dn.push_back(cyc);
        end
    end

    function automatic string qstr(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = (i == 0) ? $sformatf("%0d", q[i]) : $sformatf("%s %0d", s, q[i]);
        return s;
    endfunction

    task automatic chk_s(input string name, input string got, input string want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=\"%s\" want=\"%s\"", name, got, want);
        end
    endtask

    task automatic chk_v(input string name, input logic [8:0] got, input logic [8:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // rmode: 0 ready low, 1 ready high, 2 ready pulse on the 5th WAIT cycle of each nominal phase.
    task automatic scenario(input int len, input int rmode, input int abort_at, input int rst_at,
                            input int st0, input int st1, input int st2, input int st3);
        bus.start = 0; bus.abort = 0; bus.ready_sqrt = 0; rst = 1;
        q_ss.delete(); q_ld.delete(); q_dn.delete();
        cyc = -2;
        repeat (2) begin
            @(posedge clk); #1; cyc++;
        end
        rst = 0;
        for (int c = 0; c < len; c++) begin
            bus.start = (c == st0) || (c == st1) || (c == st2) || (c == st3);
            bus.abort = (c == abort_at);
            rst       = (c == rst_at);
            case (rmode)
                0:       bus.ready_sqrt = 1'b0;
                1:       bus.ready_sqrt = 1'b1;
                default: bus.ready_sqrt = (c == 7) || (c == 17) || (c == 27);
            endcase
            @(posedge clk); #1; cyc++;
        end
    endtask

    initial begin
        rst = 1; bus.start = 0; bus.abort = 0; bus.ready_sqrt = 0;

        // Nominal run with ignored starts at 5 and 31, accepted start at 32.
        scenario(36, 2, -1, -1, 0, 5, 31, 32);
        chk_v("reset_state", snap[0], 9'b11_0_0_0_0_0_0_0);
        chk_s("nom_start_sqrt", qstr(q_ss), "1 11 21 33");
        chk_s("nom_sqrt_ready", qstr(q_ld), "10 20 30");
        chk_s("nom_done", qstr(q_dn), "31");
        chk_v("nom_ph0", snap[1], 9'b00_0_0_1_0_1_0_0);
        chk_v("nom_ph1", snap[11], 9'b01_1_0_1_0_1_0_0);
        chk_v("nom_ph2", snap[21], 9'b10_1_1_1_0_1_0_0);
        chk_v("nom_done_cyc", snap[31], 9'b11_1_1_0_0_0_1_0);
        chk_v("nom_idle_hold", snap[32], 9'b11_1_1_0_0_0_0_0);
        chk_v("nom_restart", snap[33], 9'b00_0_0_1_0_1_0_0);

        // Stale ready: readySqrt high throughout.
        scenario(24, 1, -1, -1, 0, -1, -1, -1);
        chk_s("stale_start_sqrt", qstr(q_ss), "1 7 13");
        chk_s("stale_sqrt_ready", qstr(q_ld), "6 12 18");
        chk_s("stale_done", qstr(q_dn), "19");

        // Timeout, then restart from ERR.
        scenario(74, 0, -1, -1, 0, 70, -1, -1);
        chk_v("to_last_wait", snap[66], 9'b00_0_0_0_0_1_0_0);
        chk_v("to_err", snap[67], 9'b11_0_0_0_0_0_0_1);
        chk_v("to_err_hold", snap[70], 9'b11_0_0_0_0_0_0_1);
        chk_v("to_restart", snap[71], 9'b00_0_0_1_0_1_0_0);
        chk_s("to_no_load", qstr(q_ld), "");
        chk_s("to_start_sqrt", qstr(q_ss), "1 71");

        // Abort in phase 1 WAIT.
        scenario(40, 2, 14, -1, 0, -1, -1, -1);
        chk_v("abort_wait_idle", snap[15], 9'b11_1_0_0_0_0_0_0);
        chk_s("abort_wait_done", qstr(q_dn), "");
        chk_s("abort_wait_ss", qstr(q_ss), "1 11");

        // Abort coinciding with phase 2 LOAD.
        scenario(40, 2, 30, -1, 0, -1, -1, -1);
        chk_v("abort_load_cyc", snap[30], 9'b10_1_1_0_0_1_0_0);
        chk_s("abort_load_ld", qstr(q_ld), "10 20");
        chk_s("abort_load_done", qstr(q_dn), "");
        chk_v("abort_load_idle", snap[31], 9'b11_1_1_0_0_0_0_0);

        // Reset mid-operation.
        scenario(40, 2, -1, 15, 0, -1, -1, -1);
        chk_v("rst_mid_next", snap[16], 9'b11_0_0_0_0_0_0_0);
        chk_s("rst_mid_ss", qstr(q_ss), "1 11");
        chk_s("rst_mid_ld", qstr(q_ld), "10");
        chk_s("rst_mid_done", qstr(q_dn), "");

        // Randomised traffic; every cycle checked against the model.
        cyc = -100000;
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                rst       = ($urandom_range(499) == 0);
                bus.start = ($urandom_range(7) == 0);
                bus.abort = ($urandom_range(59) == 0);
                case (seg)
                    0:       bus.ready_sqrt = ($urandom_range(3) == 0);
                    1:       bus.ready_sqrt = ($urandom_range(79) == 0);
                    default: bus.ready_sqrt = ($urandom_range(9) != 0);
                endcase
                @(posedge clk); #1; cyc++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
